// File: rtl/count_led.sv
// Heartbeat LED counter: divides clk by DECIMATION and steps a 10-bit count on runled.
// Optional build macro COUNT_LED_GRAY_EN drives runled with the Gray-coded count instead of binary.
module count_led #(
    parameter logic [19:0] DECIMATION = 20'd1000000
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] runled
);

    localparam int unsigned DIV_W = 20;
    localparam int unsigned LED_W = 10;

    // DECIMATION of 0 or 1 collapses to a terminal count of 0, i.e. a tick every clock
    localparam logic [DIV_W-1:0] DIV_LAST =
        (DECIMATION <= DIV_W'(1)) ? '0 : DIV_W'(DECIMATION - DIV_W'(1));

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [LED_W-1:0] count;
    logic [LED_W-1:0] count_next_c;
    logic [LED_W-1:0] led_next_c;

    // Prescaler: wraps at DIV_LAST and registers a one-cycle tick on the wrap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            tick    <= 1'b1;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
            tick    <= 1'b0;
        end
    end

    assign count_next_c = count + LED_W'(1);

`ifdef COUNT_LED_GRAY_EN
    // Encode the incremented value so runled updates on the same edge as the count
    assign led_next_c = count_next_c ^ (count_next_c >> 1);
`else
    assign led_next_c = count_next_c;
`endif

    // LED counter and output register, both advanced on the edge where tick is high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            runled <= '0;
        end else if (tick) begin
            count  <= count_next_c;
            runled <= led_next_c;
        end
    end

endmodule

// File: tb/tb_count_led.sv
// Scoreboard bench for count_led: two instances (DECIMATION=20 and DECIMATION=1) under randomized reset.
// Expected runled values derive from the count of clock edges seen since reset release.
module tb_count_led;

    localparam int unsigned DEC_A = 20;
    localparam int unsigned DEC_B = 1;

    typedef struct packed {
        logic [9:0] exp_a;
        logic [9:0] exp_b;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [9:0] runled_a;
    logic [9:0] runled_b;

    int   checks   = 0;
    int   failures = 0;
    int   edges    = 0;   // rising edges sampled with reset released
    bit   done     = 1'b0;
    exp_t sb_q[$];

    count_led #(.DECIMATION(20'(DEC_A))) u_dut_a (.clk(clk), .reset(reset), .runled(runled_a));
    count_led #(.DECIMATION(20'(DEC_B))) u_dut_b (.clk(clk), .reset(reset), .runled(runled_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Steps taken after k released edges: ticks land on edges N, 2N, ... and show one edge later
    function automatic logic [9:0] model(input int k, input int unsigned n);
        logic [9:0] v;
        v = (k == 0) ? 10'd0 : 10'((k - 1) / int'(n));
`ifdef COUNT_LED_GRAY_EN
        v = v ^ (v >> 1);
`endif
        return v;
    endfunction

    task automatic push_expect();
        exp_t e;
        e.exp_a = model(edges, DEC_A);
        e.exp_b = model(edges, DEC_B);
        sb_q.push_back(e);
    endtask

    // One clock: account for the edge, then change reset 2 ns later (mid-cycle, async)
    task automatic cycle(input logic rst_val);
        @(posedge clk);
        if (reset) edges++;
        #2;
        reset = rst_val;
        if (!rst_val) edges = 0;
        push_expect();
    endtask

    task automatic run(input int n, input logic rst_val);
        for (int i = 0; i < n; i++) cycle(rst_val);
    endtask

    // Monitor: pops one expectation per cycle and compares both instances
    always @(negedge clk) begin
        exp_t e;
        if (!done && sb_q.size() != 0) begin
            e = sb_q.pop_front();
            checks++;
            if (runled_a !== e.exp_a) begin
                failures++;
                $display("FAIL runled_dec20 t=%0t actual=%0d expected=%0d", $time, runled_a, e.exp_a);
            end
            checks++;
            if (runled_b !== e.exp_b) begin
                failures++;
                $display("FAIL runled_dec1 t=%0t actual=%0d expected=%0d", $time, runled_b, e.exp_b);
            end
        end
    end

    initial begin
        int len;
        reset = 1'b0;
        #1;
        checks++;
        if (runled_a !== 10'd0 || runled_b !== 10'd0) begin
            failures++;
            $display("FAIL reset_value actual=%0d/%0d expected=0/0", runled_a, runled_b);
        end
        run(100, 1'b0);                  // long reset hold
        run(130, 1'b1);                  // basic stepping, several DECIMATION=20 steps
        run(3, 1'b0);                    // mid-operation reset
        run(4, 1'b1);                    // short release pulse
        run(2, 1'b0);
        run(1100, 1'b1);                 // DECIMATION=1 instance wraps 1023 -> 0
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(199) == 0) begin
                len = int'($urandom_range(4, 1));
                run(len, 1'b0);
            end else begin
                cycle(1'b1);
            end
        end
        run(30, 1'b1);
        @(negedge clk);
        @(posedge clk);
        done = 1'b1;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
